johnson_counter_arbiter: RTL and testbench
==========================================

Name: johnson_counter_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4-bit Johnson counter among NUM_REQ requesters. Each requester asks for a run of N counter steps. The arbiter grants one requester at a time and drives the counter's reset, start and stop commands. It uses the counter's running flag as the acknowledge for start and stop, then returns a per-requester done pulse. It sits between client logic and the shared Johnson counter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
STEP_WIDTH, 8, width of each requested step count
ACK_TIMEOUT, 15, maximum cycles to wait for the running flag to change before aborting

Ports:
Clk_In  in  1  clock; all logic on posedge
Reset_N_In  in  1  asynchronous, active-low reset
Enable_In  in  1  when low, no new grants; an in-flight run completes normally
Req_In  in  NUM_REQ  per-requester request level
Steps_In  in  NUM_REQ*STEP_WIDTH  packed step counts; slice i belongs to requester i
Error_Clear_In  in  1  clears the sticky error
Counter_Running_Flag_In  in  1  running flag from the shared counter
Grant_Out  in/out: out  NUM_REQ  one-hot grant
Done_Out  out  NUM_REQ  one-cycle completion pulse per requester
Busy_Out  out  1  high whenever state is not IDLE
Error_Out  out  1  sticky ack-timeout error
Counter_Reset_Out  out  1  active-high reset pulse to the counter
Start_Counter_Command_Out  out  1  start command to the counter
Stop_Counter_Command_Out  out  1  stop command to the counter

Behaviour:
- Clock and reset: one clock, Clk_In. Reset is asynchronous, active-low, on Reset_N_In. During reset all outputs are 0, the state is IDLE, the timeout counter is 0, and the last-grant pointer is NUM_REQ-1, so requester 0 has first priority.
- Outputs are Moore outputs, decoded from the registered state and the latched index only.
- IDLE:
  - If Enable_In and any Req_In bit is set, pick the first set bit searching upward from last+1 (wrapping).
  - Latch that index and its Steps_In slice.
  - If the slice is 0, go to DONE (no counter activity); otherwise go to CLEAR.
- CLEAR (exactly 1 cycle): Counter_Reset_Out=1, so the counter reloads 0001. Next state is START.
- START:
  - Start_Counter_Command_Out=1.
  - When Counter_Running_Flag_In=1, load remaining=steps and go to RUN.
  - After ACK_TIMEOUT cycles without the flag, go to ABORT.
- RUN:
  - No commands asserted; decrement remaining each cycle.
  - When remaining==1, go to STOP.
  - RUN therefore lasts exactly steps cycles.
- STOP:
  - Stop_Counter_Command_Out=1.
  - When Counter_Running_Flag_In=0, go to DONE.
  - On timeout, go to ABORT.
- DONE (1 cycle): Done_Out[idx]=1, last=idx, then return to IDLE.
- ABORT (1 cycle):
  - Counter_Reset_Out=1, Error_Out set, Done_Out[idx]=1, last=idx, then return to IDLE.
  - A reset pulse leaves the counter stopped.
- Grant_Out[idx] is high in CLEAR, START, RUN, STOP, DONE and ABORT, and low in IDLE.
- Start and stop are never asserted in the same cycle.
- The timeout counter clears on every state change.
- Requester behaviour:
  - Deasserting Req_In mid-run is ignored; the run completes.
  - Steps_In is sampled only in IDLE.
  - A requester still requesting after its Done is eligible again, but at lowest priority.
- Enable_In low in IDLE holds IDLE. Enable_In low mid-run has no effect on the run.
- Error_Clear_In clears Error_Out. If clear and a new abort occur in the same cycle, the set wins.
- Latency: Req_In sampled at edge k gives Grant_Out and Counter_Reset_Out at edge k+1, and Start_Counter_Command_Out at edge k+2.
- Reset mid-operation: all outputs drop immediately. The counter is left in whatever state it was in; the next grant's CLEAR re-initialises it.

Decomposition:
- Shared package johnson_arb_pkg holds:
  - the state enum (IDLE, CLEAR, START, RUN, STOP, DONE, ABORT);
  - ACK_TIMEOUT_W = $clog2(ACK_TIMEOUT+1);
  - reset values of the pointer and outputs.
- One sub-module, rr_arbiter (parameter NUM_REQ):
  - inputs: request vector, last pointer;
  - outputs: one-hot winner, winner index, valid.
  - It is purely combinational.

Test Plan:
1. Req_In=0001, steps0=5, counter model ack after 1 cycle -> Grant_Out=0001; one Counter_Reset_Out pulse; RUN lasts 5 cycles; counter shows 0001→0011→0111→1111→1110→1100 region; Done_Out=0001 pulse; Busy_Out low after.
2. Req_In=1111 held, all steps=2 -> grant order 0,1,2,3,0; one Done pulse per requester, one-hot.
3. steps2=0, Req_In=0100 -> DONE the cycle after IDLE; no reset, start or stop asserted; Done_Out=0100.
4. Running flag held 0 during START -> after 15 cycles go to ABORT; Counter_Reset_Out pulse; Error_Out=1 and stays; Error_Clear_In clears it; an abort coinciding with the clear keeps it at 1.
5. Enable_In=0 with Req_In=0010 -> no grant. Enable_In=1 -> grant. Enable_In dropped during RUN -> the run still completes with all steps.
6. Reset_N_In pulsed low during RUN -> all outputs 0 asynchronously; after release, Req_In=1000 is granted with requester 0 priority restored and a fresh CLEAR.

Source files
------------

// File: rtl/johnson_arb_pkg.sv
// johnson_arb_pkg: shared FSM states and reset values for the Johnson counter arbiter
package johnson_arb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_RUN, S_STOP, S_DONE, S_ABORT} state_t;
    localparam int ACK_TIMEOUT_DEF = 15;
    localparam int ACK_TIMEOUT_W = $clog2(ACK_TIMEOUT_DEF + 1);
    localparam logic ERROR_RST = 1'b0;
    function automatic int last_rst(input int num_req);
        return num_req - 1;
    endfunction
endpackage

// File: rtl/johnson_counter_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               valid
);
    int p;
    // scan from farthest to nearest so the nearest set bit after last is the one kept
    always_comb begin
        p = 0;
        idx = '0;
        valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            p = (int'(last) + k) % NUM_REQ;
            if (req[IW'(p)]) begin
                idx = IW'(p);
                valid = 1'b1;
            end
        end
        gnt = valid ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/johnson_counter_arbiter.sv
// johnson_counter_arbiter: round-robin sequencer sharing one Johnson counter among requesters
module johnson_counter_arbiter
    import johnson_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STEP_WIDTH = 8,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                          Clk_In,
    input  logic                          Reset_N_In,
    input  logic                          Enable_In,
    input  logic [NUM_REQ-1:0]            Req_In,
    input  logic [NUM_REQ*STEP_WIDTH-1:0] Steps_In,
    input  logic                          Error_Clear_In,
    input  logic                          Counter_Running_Flag_In,
    output logic [NUM_REQ-1:0]            Grant_Out,
    output logic [NUM_REQ-1:0]            Done_Out,
    output logic                          Busy_Out,
    output logic                          Error_Out,
    output logic                          Counter_Reset_Out,
    output logic                          Start_Counter_Command_Out,
    output logic                          Stop_Counter_Command_Out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t state, nxt;
    logic [IW-1:0] idx, last, win_idx;
    logic [NUM_REQ-1:0] win_gnt, idx_hot;
    logic win_valid, err, tmo_hit;
    logic [STEP_WIDTH-1:0] steps, rem, sel_steps;
    logic [TW-1:0] tmo;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req(Req_In),
        .last(last),
        .gnt(win_gnt),
        .idx(win_idx),
        .valid(win_valid)
    );

    // step count of the current winner, selected by its one-hot grant
    always_comb begin
        sel_steps = '0;
        for (int i = 0; i < NUM_REQ; i++)
            sel_steps |= win_gnt[i] ? Steps_In[i*STEP_WIDTH +: STEP_WIDTH] : '0;
    end

    assign tmo_hit = tmo == TW'(ACK_TIMEOUT - 1);

    // next state: the running flag acknowledges start (rise) and stop (fall)
    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = (Enable_In && win_valid) ? (sel_steps == '0 ? S_DONE : S_CLEAR) : S_IDLE;
            S_CLEAR: nxt = S_START;
            S_START: nxt = Counter_Running_Flag_In ? S_RUN : tmo_hit ? S_ABORT : S_START;
            S_RUN:   nxt = rem == STEP_WIDTH'(1) ? S_STOP : S_RUN;
            S_STOP:  nxt = !Counter_Running_Flag_In ? S_DONE : tmo_hit ? S_ABORT : S_STOP;
            default: nxt = S_IDLE;
        endcase
    end

    // state, latched request, step countdown, ack timeout, rotation pointer and sticky error
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state <= S_IDLE;
            idx <= '0;
            last <= IW'(last_rst(NUM_REQ));
            steps <= '0;
            rem <= '0;
            tmo <= '0;
            err <= ERROR_RST;
        end else begin
            state <= nxt;
            tmo <= nxt != state ? '0 : tmo + TW'(1);
            if (state == S_IDLE && nxt != S_IDLE) begin
                idx <= win_idx;
                steps <= sel_steps;
            end
            if (state == S_START) rem <= steps;
            else if (state == S_RUN) rem <= rem - STEP_WIDTH'(1);
            if (state == S_DONE || state == S_ABORT) last <= idx;
            err <= (state == S_ABORT) | (err & ~Error_Clear_In);
        end
    end

    assign idx_hot = NUM_REQ'(1) << idx;
    assign Busy_Out = state != S_IDLE;
    assign Grant_Out = Busy_Out ? idx_hot : '0;
    assign Done_Out = (state == S_DONE || state == S_ABORT) ? idx_hot : '0;
    assign Error_Out = err;
    assign Counter_Reset_Out = state == S_CLEAR || state == S_ABORT;
    assign Start_Counter_Command_Out = state == S_START;
    assign Stop_Counter_Command_Out = state == S_STOP;
endmodule

// File: tb/tb_johnson_counter_arbiter.sv
// tb_johnson_counter_arbiter: randomized and directed checks against a transaction-level model
module tb_johnson_counter_arbiter;
    localparam int NR = 4;
    localparam int SW = 8;
    localparam int TO = 15;

    logic clk = 0, rst_n = 0, en = 0, eclr = 0, flag;
    logic [NR-1:0] req = '0;
    logic [NR*SW-1:0] steps = '0;
    logic [NR-1:0] gnt, done;
    logic busy, err, crst, cstart, cstop;

    always #5 clk = ~clk;

    johnson_counter_arbiter #(.NUM_REQ(NR), .STEP_WIDTH(SW), .ACK_TIMEOUT(TO)) dut (
        .Clk_In(clk),
        .Reset_N_In(rst_n),
        .Enable_In(en),
        .Req_In(req),
        .Steps_In(steps),
        .Error_Clear_In(eclr),
        .Counter_Running_Flag_In(flag),
        .Grant_Out(gnt),
        .Done_Out(done),
        .Busy_Out(busy),
        .Error_Out(err),
        .Counter_Reset_Out(crst),
        .Start_Counter_Command_Out(cstart),
        .Stop_Counter_Command_Out(cstop)
    );

    // shared counter: running flag follows start/stop one cycle later; ack can be disabled
    logic running = 0, ack_en = 1;
    assign flag = running;
    always @(posedge clk) begin
        if (crst) running <= 1'b0;
        else if (cstart && ack_en) running <= 1'b1;
        else if (cstop) running <= 1'b0;
    end

    // per-run summary collected from the DUT outputs
    typedef struct packed {
        logic [NR-1:0] done;
        logic [NR-1:0] gnt;
        int cyc;
        int rst;
        int st;
        int sp;
        int run;
    } rec_t;

    rec_t q[$];
    int checks = 0, errors = 0, viol = 0;
    int m_last = NR - 1;

    initial begin
        int cyc, nrst, nst, nsp, nrun;
        cyc = 0; nrst = 0; nst = 0; nsp = 0; nrun = 0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                cyc = 0; nrst = 0; nst = 0; nsp = 0; nrun = 0;
            end else begin
                cyc++;
                nrst += int'(crst);
                nst += int'(cstart);
                nsp += int'(cstop);
                if (!crst && !cstart && !cstop && done == '0) nrun++;
                if (done != '0) q.push_back('{done, gnt, cyc, nrst, nst, nsp, nrun});
            end
            if ((cstart && cstop) || (busy && !$onehot(gnt)) || (!busy && gnt != '0) || (done != '0 && done != gnt))
                viol++;
        end
    end

    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++)
            if (r[(m_last + k) % NR]) return (m_last + k) % NR;
        return -1;
    endfunction

    // expected run profile: CLEAR 1, START 2 (flag rises a cycle after start), RUN s, STOP 2, DONE 1
    function automatic rec_t expect_run(input int i, input int s, input bit ab);
        rec_t e;
        e.done = NR'(1) << i;
        e.gnt = e.done;
        if (s == 0) begin e.cyc = 1; e.rst = 0; e.st = 0; e.sp = 0; e.run = 0; end
        else if (ab) begin e.cyc = TO + 2; e.rst = 2; e.st = TO; e.sp = 0; e.run = 0; end
        else begin e.cyc = s + 6; e.rst = 1; e.st = 2; e.sp = 2; e.run = s; end
        return e;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_steps(input int i, input int v);
        steps[i*SW +: SW] = SW'(v);
    endtask

    task automatic wait_done(output rec_t r);
        bit ok;
        ok = 0;
        r = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (q.size() > 0) begin
                r = q.pop_front();
                ok = 1;
            end else tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_done: no Done pulse within 300 cycles");
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick(); tick();
        checks++;
        if ({gnt, done, busy, err, crst, cstart, cstop} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {gnt, done, busy, err, crst, cstart, cstop});
        end
        rst_n = 1;
        en = 1;
        m_last = NR - 1;
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b gnt=%b want 0/0", busy, gnt);
        end
    endtask

    task automatic test_single;
        rec_t r, e;
        int w;
        req = 4'b0001;
        set_steps(0, 5);
        w = pick(req);
        e = expect_run(w, 5, 0);
        tick();
        checks++;
        if (gnt !== 4'b0001 || crst !== 1'b1 || cstart !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: gnt=%b crst=%b start=%b want 0001/1/0", gnt, crst, cstart);
        end
        tick();
        checks++;
        if (cstart !== 1'b1 || crst !== 1'b0) begin
            errors++;
            $display("FAIL single_start: start=%b crst=%b want 1/0", cstart, crst);
        end
        wait_done(r);
        req = '0;
        m_last = w;
        checks++;
        if (r !== e) begin errors++; $display("FAIL single_run: got %h want %h", r, e); end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin;
        rec_t r, e;
        int w;
        for (int i = 0; i < NR; i++) set_steps(i, 2);
        req = '1;
        for (int n = 0; n < 5; n++) begin
            w = pick(req);
            e = expect_run(w, 2, 0);
            wait_done(r);
            m_last = w;
            if (n == 4) req = '0;
            checks++;
            if (r !== e) begin errors++; $display("FAIL rr_run%0d: got %h want %h", n, r, e); end
        end
        tick(); tick();
    endtask

    task automatic test_zero_steps;
        rec_t r, e;
        int w;
        req = 4'b0100;
        set_steps(2, 0);
        w = pick(req);
        e = expect_run(w, 0, 0);
        wait_done(r);
        req = '0;
        m_last = w;
        checks++;
        if (r !== e) begin errors++; $display("FAIL zero_steps: got %h want %h", r, e); end
        tick(); tick();
    endtask

    task automatic test_timeout;
        rec_t r, e;
        int w;
        ack_en = 0;
        req = 4'b0001;
        set_steps(0, 3);
        w = pick(req);
        e = expect_run(w, 3, 1);
        wait_done(r);
        req = '0;
        m_last = w;
        checks++;
        if (r !== e) begin errors++; $display("FAIL abort_run: got %h want %h", r, e); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL abort_err_set: err=%b want 1", err); end
        tick(); tick(); tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL abort_err_sticky: err=%b want 1", err); end
        eclr = 1;
        tick();
        eclr = 0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b want 0", err); end
        eclr = 1;
        req = 4'b1000;
        set_steps(3, 1);
        w = pick(req);
        e = expect_run(w, 1, 1);
        wait_done(r);
        req = '0;
        m_last = w;
        checks++;
        if (r !== e) begin errors++; $display("FAIL abort_run2: got %h want %h", r, e); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: err=%b want 1", err); end
        eclr = 0;
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_after_clear_drop: err=%b want 1", err); end
        eclr = 1;
        tick();
        eclr = 0;
        ack_en = 1;
        tick();
    endtask

    task automatic test_enable;
        rec_t r, e;
        int w;
        en = 0;
        req = 4'b0010;
        set_steps(1, 4);
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL enable_hold: busy=%b gnt=%b want 0/0", busy, gnt);
        end
        en = 1;
        w = pick(req);
        e = expect_run(w, 4, 0);
        repeat (4) tick();
        en = 0;
        wait_done(r);
        m_last = w;
        checks++;
        if (r !== e) begin errors++; $display("FAIL enable_drop_run: got %h want %h", r, e); end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL enable_no_regrant: busy=%b want 0", busy); end
        req = '0;
        en = 1;
        tick();
    endtask

    task automatic test_reset_mid;
        rec_t r, e;
        int w;
        req = 4'b0001;
        set_steps(0, 10);
        repeat (6) tick();
        rst_n = 0;
        #1;
        checks++;
        if ({gnt, done, busy, err, crst, cstart, cstop} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %b want 0", {gnt, done, busy, err, crst, cstart, cstop});
        end
        m_last = NR - 1;
        req = 4'b1001;
        set_steps(0, 3);
        set_steps(3, 3);
        tick(); tick();
        q.delete();
        rst_n = 1;
        w = pick(req);
        e = expect_run(w, 3, 0);
        wait_done(r);
        req = '0;
        m_last = w;
        checks++;
        if (r !== e) begin errors++; $display("FAIL reset_regrant: got %h want %h", r, e); end
        tick(); tick();
    endtask

    task automatic test_random;
        rec_t r, e;
        int w, s[NR];
        for (int n = 0; n < 20; n++) begin
            req = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                s[i] = $urandom_range(0, 12);
                set_steps(i, s[i]);
            end
            w = pick(req);
            e = expect_run(w, s[w], 0);
            wait_done(r);
            m_last = w;
            checks++;
            if (r !== e) begin errors++; $display("FAIL random_run%0d: got %h want %h", n, r, e); end
        end
        req = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_steps();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL protocol: %0d cycles broke one-hot/start-stop/done-grant rules, want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
